// File: rtl/roll_scheduler.sv
// roll_scheduler: round-robin sharing of the single dice-roll engine between two requesters.
// Define ROLL_SCHED_STATS_EN to add o_rollTotal, a saturating count of accepted rolls.
//
// state  | meaning
// IDLE   | engine idle, arbitrating pending requests
// WAIT   | latched die driven, waiting for a roll or timeout
// GAP    | idle die code between consecutive rolls
// DONE   | one-cycle completion pulse to the owner
module roll_scheduler #(
   parameter int GAP_CYCLES = 10,
   parameter int TIMEOUT    = 1024
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [1:0]  i_req,
   input  logic [7:0]  i_die,
   input  logic [7:0]  i_count,
   output logic [3:0]  o_dieSelect,
   input  logic        i_rollValid,
   input  logic [4:0]  i_dieRoll,
   output logic [1:0]  o_done,
   output logic [8:0]  o_sum,
   output logic        o_err,
   output logic        o_busy,
`ifdef ROLL_SCHED_STATS_EN
   output logic [15:0] o_rollTotal,
`endif
   output logic        o_owner
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP, S_DONE} state_t;

   localparam logic [3:0]  DIE_IDLE = 4'b1111;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [7:0]  GAP_LOAD = 8'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  die_q, die_d;
   logic [3:0]  rem_q, rem_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic [8:0]  sum_q, sum_d;
   logic        err_q, err_d;
   logic [15:0] timer_q, timer_d;
   logic [7:0]  gap_q, gap_d;
   logic [3:0]  dsel_q, dsel_d;
   logic [1:0]  done_q, done_d;
   logic        busy_q, busy_d;
   logic        grant_c;
   logic [3:0]  cnt_c;
`ifdef ROLL_SCHED_STATS_EN
   logic [15:0] total_q, total_d;
`endif

   always_comb begin
      state_d = state_q;
      die_d   = die_q;
      rem_d   = rem_q;
      owner_d = owner_q;
      last_d  = last_q;
      sum_d   = sum_q;
      err_d   = err_q;
      timer_d = timer_q;
      gap_d   = gap_q;
      dsel_d  = dsel_q;
      done_d  = 2'b00;
      busy_d  = busy_q;
`ifdef ROLL_SCHED_STATS_EN
      total_d = total_q;
`endif
      // On a tie the requester not served last wins.
      grant_c = (i_req == 2'b11) ? ~last_q : i_req[1];
      cnt_c   = grant_c ? i_count[7:4] : i_count[3:0];

      case (state_q)
         S_IDLE: begin
            if (|i_req) begin
               owner_d = grant_c;
               die_d   = grant_c ? i_die[7:4] : i_die[3:0];
               rem_d   = cnt_c;
               sum_d   = 9'd0;
               timer_d = 16'd0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               if (cnt_c != 4'd0) begin
                  state_d = S_WAIT;
                  dsel_d  = die_d;
               end else begin
                  state_d = S_DONE;
                  done_d  = grant_c ? 2'b10 : 2'b01;
               end
            end
         end
         S_WAIT: begin
            timer_d = timer_q + 16'd1;
            if (i_rollValid) begin
               sum_d   = sum_q + {4'b0000, i_dieRoll};
               rem_d   = rem_q - 4'd1;
               timer_d = 16'd0;
               dsel_d  = DIE_IDLE;
`ifdef ROLL_SCHED_STATS_EN
               if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
`endif
               if (rem_q == 4'd1) begin
                  state_d = S_DONE;
                  done_d  = owner_q ? 2'b10 : 2'b01;
               end else begin
                  state_d = S_GAP;
                  gap_d   = GAP_LOAD;
               end
            end else if (timer_q == TMO_LAST) begin
               err_d   = 1'b1;
               dsel_d  = DIE_IDLE;
               state_d = S_DONE;
               done_d  = owner_q ? 2'b10 : 2'b01;
            end
         end
         S_GAP: begin
            if (gap_q == 8'd0) begin
               state_d = S_WAIT;
               dsel_d  = die_q;
               timer_d = 16'd0;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         S_DONE: begin
            last_d  = owner_q;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         die_q   <= DIE_IDLE;
         rem_q   <= 4'd0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         sum_q   <= 9'd0;
         err_q   <= 1'b0;
         timer_q <= 16'd0;
         gap_q   <= 8'd0;
         dsel_q  <= DIE_IDLE;
         done_q  <= 2'b00;
         busy_q  <= 1'b0;
`ifdef ROLL_SCHED_STATS_EN
         total_q <= 16'd0;
`endif
      end else begin
         state_q <= state_d;
         die_q   <= die_d;
         rem_q   <= rem_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         sum_q   <= sum_d;
         err_q   <= err_d;
         timer_q <= timer_d;
         gap_q   <= gap_d;
         dsel_q  <= dsel_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
`ifdef ROLL_SCHED_STATS_EN
         total_q <= total_d;
`endif
      end
   end

   assign o_dieSelect = dsel_q;
   assign o_done      = done_q;
   assign o_sum       = sum_q;
   assign o_err       = err_q;
   assign o_busy      = busy_q;
   assign o_owner     = owner_q;
`ifdef ROLL_SCHED_STATS_EN
   assign o_rollTotal = total_q;
`endif

endmodule

// File: tb/tb_roll_scheduler.sv
// Directed plus randomized bench for roll_scheduler; expected values come from a
// transaction-level model (arbitration by last-served, sums by plain arithmetic).
module tb_roll_scheduler;
   localparam int GAP = 10;
   localparam int TMO = 1024;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] i_req;
   logic [7:0] i_die;
   logic [7:0] i_count;
   logic [3:0] o_dieSelect;
   logic       i_rollValid;
   logic [4:0] i_dieRoll;
   logic [1:0] o_done;
   logic [8:0] o_sum;
   logic       o_err;
   logic       o_busy;
   logic       o_owner;
`ifdef ROLL_SCHED_STATS_EN
   logic [15:0] o_rollTotal;
`endif

   roll_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
      .i_clk(clk),
      .i_reset(rst),
      .i_req(i_req),
      .i_die(i_die),
      .i_count(i_count),
      .o_dieSelect(o_dieSelect),
      .i_rollValid(i_rollValid),
      .i_dieRoll(i_dieRoll),
      .o_done(o_done),
      .o_sum(o_sum),
      .o_err(o_err),
      .o_busy(o_busy),
`ifdef ROLL_SCHED_STATS_EN
      .o_rollTotal(o_rollTotal),
`endif
      .o_owner(o_owner)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int last_served;
   int exp_total;
   int tmo_at;
   int q_roll[$];
   int q_delay[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [1:0] r);
      if (r == 2'b11) return 1 - last_served;
      return r[1] ? 1 : 0;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_dsel"}, o_dieSelect, 4'hF);
      chk({tag, "_done"}, o_done, 2'b00);
      chk({tag, "_sum"}, o_sum, 0);
      chk({tag, "_err"}, o_err, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_owner"}, o_owner, 0);
   endtask

   // Drives one request from IDLE through DONE, checking every cycle; returns in IDLE.
   task automatic serve(input int who, input logic [3:0] die, input int cnt);
      int exp_sum;
      int d;
      int roll;
      bit timed_out;
      logic [1:0] hot;
      exp_sum   = 0;
      timed_out = 1'b0;
      hot       = (who == 1) ? 2'b10 : 2'b01;
      i_req[who] = 1'b1;
      i_die[4*who +: 4]   = die;
      i_count[4*who +: 4] = 4'(cnt);
      @(negedge clk);
      chk("grant_busy", o_busy, 1);
      chk("grant_owner", o_owner, who);
      chk("grant_sum_clr", o_sum, 0);
      chk("grant_err_clr", o_err, 0);
      chk("grant_dsel", o_dieSelect, (cnt != 0) ? die : 4'hF);
      i_die[4*who +: 4]   = 4'($urandom);
      i_count[4*who +: 4] = 4'($urandom);
      for (int r = 0; r < cnt && !timed_out; r++) begin
         if (r == tmo_at) begin
            for (int j = 0; j < TMO; j++) begin
               chk("tmo_dsel", o_dieSelect, die);
               @(negedge clk);
            end
            timed_out = 1'b1;
         end else begin
            if (q_delay.size() != 0) d = q_delay.pop_front();
            else if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 200);
            else d = $urandom_range(0, 12);
            if (q_roll.size() != 0) roll = q_roll.pop_front();
            else roll = $urandom_range(1, 20);
            for (int j = 0; j < d; j++) begin
               chk("wait_dsel", o_dieSelect, die);
               chk("wait_nodone", o_done, 2'b00);
               @(negedge clk);
            end
            i_rollValid = 1'b1;
            i_dieRoll   = 5'(roll);
            @(negedge clk);
            i_rollValid = 1'b0;
            exp_sum += roll;
            exp_total++;
            chk("acc_sum", o_sum, exp_sum);
            if (r < cnt - 1) begin
               for (int g = 0; g < GAP; g++) begin
                  chk("gap_dsel", o_dieSelect, 4'hF);
                  chk("gap_sum", o_sum, exp_sum);
                  chk("gap_busy", o_busy, 1);
                  i_rollValid = 1'($urandom);
                  i_dieRoll   = 5'($urandom_range(1, 20));
                  @(negedge clk);
               end
               i_rollValid = 1'b0;
               chk("gap_end_dsel", o_dieSelect, die);
            end
         end
      end
      chk("done_pulse", o_done, hot);
      chk("done_sum", o_sum, exp_sum);
      chk("done_err", o_err, timed_out);
      chk("done_dsel", o_dieSelect, 4'hF);
      chk("done_busy", o_busy, 1);
      i_req[who] = 1'b0;
      @(negedge clk);
      chk("post_done", o_done, 2'b00);
      chk("post_busy", o_busy, 0);
      chk("post_dsel", o_dieSelect, 4'hF);
      chk("post_sum_hold", o_sum, exp_sum);
      chk("post_err_hold", o_err, timed_out);
`ifdef ROLL_SCHED_STATS_EN
      chk("roll_total", o_rollTotal, exp_total);
`endif
      last_served = who;
      tmo_at = -1;
   endtask

   initial begin
      logic [1:0] mask;
      int w;
      rst = 1'b1;
      i_req = 2'b00;
      i_die = 8'h00;
      i_count = 8'h00;
      i_rollValid = 1'b0;
      i_dieRoll = 5'd0;
      tmo_at = -1;
      last_served = 1;
      exp_total = 0;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("idle");

      // single roll, fixed value after 30 cycles
      q_delay = {30};
      q_roll  = {17};
      serve(0, 4'b0101, 1);

      // three rolls with gaps
      q_delay = {3, 0, 8};
      q_roll  = {4, 6, 2};
      serve(1, 4'b0011, 3);

      // simultaneous requests: alternation, then a tie favouring requester 1
      for (int k = 0; k < 2; k++) begin
         i_die[7:4] = 4'h9;
         i_count[7:4] = 4'd2;
         i_req = 2'b11;
         w = pick(i_req);
         serve(w, 4'h6, 2);
         serve(1 - w, 4'h9, 2);
      end
      serve(0, 4'h1, 1);
      i_die[3:0] = 4'h2;
      i_count[3:0] = 4'd1;
      i_req = 2'b11;
      w = pick(i_req);
      serve(w, 4'h8, 1);
      serve(1 - w, 4'h2, 1);

      // timeouts: no roll at all, valid on the final timer cycle, partial sum kept
      tmo_at = 0;
      serve(0, 4'h7, 1);
      q_delay = {TMO - 1};
      q_roll  = {20};
      serve(1, 4'h2, 1);
      tmo_at = 1;
      serve(0, 4'hC, 3);

      // zero-count request
      serve(1, 4'h4, 0);

      // reset while waiting on the second roll of a 3-roll request
      i_req[1] = 1'b1;
      i_die[7:4] = 4'hA;
      i_count[7:4] = 4'd3;
      @(negedge clk);
      chk("rst_pre_owner", o_owner, 1);
      i_rollValid = 1'b1;
      i_dieRoll = 5'd11;
      @(negedge clk);
      i_rollValid = 1'b0;
      repeat (GAP + 4) @(negedge clk);
      chk("rst_pre_dsel", o_dieSelect, 4'hA);
      rst = 1'b1;
      i_req = 2'b00;
      #1;
      chk_reset_vals("rst_async");
      @(negedge clk);
      chk("rst_no_done", o_done, 2'b00);
      rst = 1'b0;
      last_served = 1;
      exp_total = 0;
      @(negedge clk);
      chk_reset_vals("rst_idle");
      serve(0, 4'h5, 2);

      // randomized mixes of requesters, dies and counts
      for (int it = 0; it < 12; it++) begin
         mask = 2'($urandom_range(1, 3));
         i_die = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 14))};
         i_count = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 6))};
         i_req = mask;
         for (int k = 0; k < 2; k++) begin
            if (i_req != 2'b00) begin
               w = pick(i_req);
               serve(w, i_die[4*w +: 4], int'(i_count[4*w +: 4]));
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
